// File: rtl/seven_seg_arbiter_if.sv
// Client-side request bus and display-driver outputs of the seven-segment arbiter.
// The master side is the clients and driver; the slave side is the arbiter itself.
interface seven_seg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_din;
  logic [N_REQ-1:0]    req_bcd;
  logic [2*N_REQ-1:0]  req_dec;
  logic [N_REQ-1:0]    gnt;
  logic [PTR_W-1:0]    owner;
  logic [15:0]         din;
  logic                bcd;
  logic [1:0]          dec;
  logic                enable;

  modport master (
    output req, req_din, req_bcd, req_dec,
    input  gnt, owner, din, bcd, dec, enable
  );

  modport slave (
    input  req, req_din, req_bcd, req_dec,
    output gnt, owner, din, bcd, dec, enable
  );
endinterface

// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter time-sharing one 4-digit seven-segment driver between clients,
// with a minimum dwell per grant and a single blank cycle between owners.
module seven_seg_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int PTR_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_arbiter_if.slave bus
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [15:0]      r_din;
  logic             r_bcd;
  logic [1:0]       r_dec;
  logic             r_en;

  logic             w_pick_vld;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_own_req;
  logic             w_others;
  logic [15:0]      w_own_din;
  logic             w_own_bcd;
  logic [1:0]       w_own_dec;
  logic [15:0]      w_pick_din;
  logic             w_pick_bcd;
  logic [1:0]       w_pick_dec;

  assign bus.gnt    = r_gnt;
  assign bus.owner  = r_owner;
  assign bus.din    = r_din;
  assign bus.bcd    = r_bcd;
  assign bus.dec    = r_dec;
  assign bus.enable = r_en;

  // Scan from farthest to nearest offset so the closest requester after the owner wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = r_owner;
    for (int i = N_REQ; i >= 1; i--) begin
      w_pick_idx = bus.req[(int'(r_owner) + i) % N_REQ] ? PTR_W'((int'(r_owner) + i) % N_REQ) : w_pick_idx;
      w_pick_vld = bus.req[(int'(r_owner) + i) % N_REQ] ? 1'b1 : w_pick_vld;
    end
  end

  assign w_own_req  = bus.req[r_owner];
  assign w_others   = |(bus.req & ~r_gnt);
  assign w_own_din  = bus.req_din[16*r_owner +: 16];
  assign w_own_bcd  = bus.req_bcd[r_owner];
  assign w_own_dec  = bus.req_dec[2*r_owner +: 2];
  assign w_pick_din = bus.req_din[16*w_pick_idx +: 16];
  assign w_pick_bcd = bus.req_bcd[w_pick_idx];
  assign w_pick_dec = bus.req_dec[2*w_pick_idx +: 2];

  // Arbitration state machine; every output is a register updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= LAST_IDX;
      r_cnt   <= {CNT_W{1'b0}};
      r_gnt   <= {N_REQ{1'b0}};
      r_din   <= 16'h0000;
      r_bcd   <= 1'b0;
      r_dec   <= 2'b00;
      r_en    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_BLANK: begin
          if (w_pick_vld) begin
            r_state <= ST_SHOW;
            r_owner <= w_pick_idx;
            r_gnt   <= ONE_HOT0 << w_pick_idx;
            r_en    <= 1'b1;
            r_din   <= w_pick_din;
            r_bcd   <= w_pick_bcd;
            r_dec   <= w_pick_dec;
            r_cnt   <= RELOAD;
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= {N_REQ{1'b0}};
            r_en    <= 1'b0;
          end
        end
        ST_SHOW: begin
          r_din <= w_own_din;
          r_bcd <= w_own_bcd;
          r_dec <= w_own_dec;
          if (!w_own_req) begin
            r_state <= ST_BLANK;
            r_gnt   <= {N_REQ{1'b0}};
            r_en    <= 1'b0;
          end else if (r_cnt == {CNT_W{1'b0}}) begin
            // Dwell expired: hand over only if someone else is waiting.
            if (w_others) begin
              r_state <= ST_BLANK;
              r_gnt   <= {N_REQ{1'b0}};
              r_en    <= 1'b0;
            end else begin
              r_cnt <= RELOAD;
            end
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= {N_REQ{1'b0}};
          r_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every
// cycle against a behavioural model of the arbitration rules.
module tb_seven_seg_arbiter;
  localparam int NR = 4;
  localparam int DW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seven_seg_arbiter_if #(.N_REQ(NR), .PTR_W(2)) bus ();

  seven_seg_arbiter #(.N_REQ(NR), .DWELL_CYCLES(DW), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 showing, 2 blank; age counts dwell edges since grant/reload.
  int          m_mode;
  int          m_owner;
  int          m_age;
  logic [15:0] m_din;
  logic        m_bcd;
  logic [1:0]  m_dec;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_mode  = 0;
    m_owner = NR - 1;
    m_age   = 0;
    m_din   = 16'h0000;
    m_bcd   = 1'b0;
    m_dec   = 2'b00;
  endtask

  task automatic mdl_load(input int k);
    m_din = bus.req_din[16*k +: 16];
    m_bcd = bus.req_bcd[k];
    m_dec = bus.req_dec[2*k +: 2];
  endtask

  task automatic mdl_step();
    logic [NR-1:0] r;
    int  k;
    bit  hit;
    r = bus.req;
    if (m_mode == 1) begin
      mdl_load(m_owner);
      if (!r[m_owner]) m_mode = 2;
      else if (m_age >= DW - 1) begin
        if ((r & ~(4'b0001 << m_owner)) != 4'b0000) m_mode = 2;
        else m_age = 0;
      end else m_age++;
    end else begin
      hit = 1'b0;
      k   = 0;
      for (int i = 1; i <= NR && !hit; i++) begin
        k = (m_owner + i) % NR;
        if (r[k]) hit = 1'b1;
      end
      if (hit) begin
        m_mode  = 1;
        m_owner = k;
        m_age   = 0;
        mdl_load(k);
      end else m_mode = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
    check_val({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    check_val({tag, ".en"}, 32'(bus.enable), 32'(m_mode == 1));
    check_val({tag, ".owner"}, 32'(bus.owner), 32'(m_owner));
    check_val({tag, ".din"}, 32'(bus.din), 32'(m_din));
    check_val({tag, ".bcd"}, 32'(bus.bcd), 32'(m_bcd));
    check_val({tag, ".dec"}, 32'(bus.dec), 32'(m_dec));
  endtask

  task automatic tick(input string tag);
    mdl_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    mdl_reset();
    #10;
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req     = 4'b0000;
    bus.req_din = 64'h4444_3333_2222_1111;
    bus.req_bcd = 4'b0000;
    bus.req_dec = 8'h00;
    @(posedge clk);
    #1;
    do_reset();
    check_val("rst.owner_const", 32'(bus.owner), 32'd3);

    // Single requester held: granted, never blanked across dwell reloads.
    bus.req_din[15:0] = 16'h1234;
    bus.req_bcd[0]    = 1'b0;
    bus.req_dec[1:0]  = 2'd2;
    bus.req           = 4'b0001;
    tick("single");
    check_val("single.din_const", 32'(bus.din), 32'h1234);
    check_val("single.dec_const", 32'(bus.dec), 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick("single_hold");
      check_val("single.no_blank", 32'(bus.enable), 32'd1);
    end

    // All four requesting: 0,1,2,3,0 with one blank between owners.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 22; i++) tick("rr");
    check_val("rr.owner_end", 32'(bus.owner), 32'd0);

    // Owner 1 releases early while client 3 waits; client 2 is skipped.
    do_reset();
    bus.req = 4'b1010;
    tick("early");
    check_val("early.gnt1", 32'(bus.gnt), 32'b0010);
    tick("early");
    bus.req = 4'b1000;
    tick("early");
    check_val("early.blank", 32'(bus.enable), 32'd0);
    tick("early");
    check_val("early.gnt3", 32'(bus.gnt), 32'b1000);

    // Live update of the owner's value passes with one edge latency.
    do_reset();
    bus.req_din[15:0] = 16'h0005;
    bus.req = 4'b0001;
    tick("live");
    bus.req_din[15:0] = 16'h0009;
    tick("live");
    check_val("live.din9", 32'(bus.din), 32'h0009);
    check_val("live.gnt", 32'(bus.gnt), 32'b0001);

    // Everyone drops: one blank, then idle with data held.
    bus.req = 4'b0000;
    tick("drop");
    tick("drop");
    check_val("drop.din_hold", 32'(bus.din), 32'h0009);
    check_val("drop.en", 32'(bus.enable), 32'd0);

    // Asynchronous reset in the middle of a grant.
    bus.req = 4'b0001;
    tick("arst");
    tick("arst");
    #2;
    rst = 1'b1;
    #1;
    mdl_reset();
    check_all("arst_now");
    check_val("arst.din_const", 32'(bus.din), 32'h0000);
    #2;
    rst     = 1'b0;
    bus.req = 4'b0010;
    tick("arst_rel");
    check_val("arst.owner1", 32'(bus.owner), 32'd1);

    // Randomized traffic with live data changes.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
        else if (bus.req[i] && $urandom_range(0, 9) == 0) bus.req[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          bus.req_din[16*i +: 16] = 16'($urandom);
          bus.req_bcd[i]          = 1'($urandom);
          bus.req_dec[2*i +: 2]   = 2'($urandom);
        end
      end
      if ($urandom_range(0, 49) == 0) bus.req = 4'b0000;
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/seven_seg_arbiter.md
Name: seven_seg_arbiter

Overview:
- Time-shares the single 4-digit seven-segment driver between up to N_REQ client blocks (e.g. switch readback, counter, status codes).
- Each client raises a request with its own value, mode and decimal point. The arbiter grants the display round-robin, holds each owner for a minimum dwell time, and inserts a blank cycle between owners.
- Its outputs drive the seven-segment driver's din/bcd/dec/enable inputs directly.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DWELL_CYCLES, 100000000, minimum display time per grant in clk cycles (1 s at 100 MHz); must be >= 1
- PTR_W, 2, width of owner index; must equal clog2(N_REQ)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-client display request, level-sensitive
- req_din  input  16*N_REQ  packed values; client i at [16*i+15:16*i]
- req_bcd  input  N_REQ  per-client mode, 1 decimal / 0 hex
- req_dec  input  2*N_REQ  per-client decimal point position
- gnt  output  N_REQ  one-hot grant, all-zero when no owner
- owner  output  PTR_W  index of current or last owner
- din  output  16  value to driver
- bcd  output  1  mode to driver
- dec  output  2  decimal point to driver
- enable  output  1  display on to driver

Behaviour:
- Reset (async, asserted): state=IDLE, gnt=0, din=0, bcd=0, dec=0, enable=0, owner=N_REQ-1 (so client 0 has first priority), dwell counter=0. Release is synchronous to the next clk edge.
- All outputs are registered. gnt, enable and the data outputs change on the same edge, so the data always belongs to the granted client.
- Round-robin pick: first index with req=1 searching owner+1, owner+2, ... modulo N_REQ, ending at owner itself. owner updates only on a new grant.
- States:
  - IDLE:
    - gnt=0, enable=0, din/bcd/dec hold their last value.
    - If any req=1 at an edge, pick client k → SHOW: gnt=1<<k, owner=k, enable=1, din/bcd/dec loaded from client k, counter=DWELL_CYCLES-1.
  - SHOW:
    - Every edge: din/bcd/dec reload from owner's inputs, so live updates pass with 1-cycle latency. Counter decrements while nonzero.
    - Owner req=0 at any edge (early release, even mid-dwell) → BLANK.
    - Else counter==0 and another client requests (req & ~gnt nonzero) → BLANK.
    - Else counter==0 and only owner requests → stay SHOW, counter reloads DWELL_CYCLES-1, gnt unchanged, no blank.
    - Else stay SHOW.
  - BLANK:
    - Exactly one cycle, gnt=0, enable=0.
    - At the next edge: pick by round-robin from current req → SHOW as from IDLE; none → IDLE.
    - The previous owner is eligible only if no other client requests.
- Simultaneous requests: round-robin order only; there is no fixed priority beyond the reset pointer.
- req_* data of non-granted clients is ignored.
- A req pulse that drops before being sampled at an edge is lost; clients hold req until they see gnt.
- Reset mid-SHOW: outputs clear immediately (asynchronously) and the pointer returns to N_REQ-1.

Test Plan (DWELL_CYCLES=4, N_REQ=4):
- Reset then req=0001, req_din[0]=16'h1234, bcd=0, dec=2 → one edge later gnt=0001, enable=1, din=1234, dec=2, owner=0; held while req stays high, counter reloads, no blank cycles.
- From reset, req=1111 held → grant sequence 0,1,2,3,0, each SHOW 4 cycles, a 1-cycle enable=0/gnt=0 gap between each.
- Owner 1 in SHOW drops req after 2 cycles while req[3]=1 → BLANK next edge, then gnt=1000; client 2 idle is skipped.
- While owner 0 in SHOW, change req_din[0] from 0005 to 0009 → din=0009 one edge later, gnt unchanged.
- Assert rst mid-SHOW (asynchronous, between edges) → gnt, din, enable 0 immediately; after release with req=0010, first grant goes to client 1 (pointer reset to 3).
- All req drop during SHOW → BLANK one cycle, then IDLE, enable=0, din holds last value.
